// File: rtl/toggle_cover_collector.sv
// Toggle-coverage collector: sticky rise/fall bitmaps per bit, first hits reported once as indexed events.
// Latency: a toggle sampled at edge t is presented at edge t+1; a stalled event holds its index and pending hits queue losslessly.
module toggle_cover_collector #(
  parameter int          WIDTH       = 65,
  parameter logic [63:0] COVER_INDEX = 64'd0,
  parameter int          COVER_TOTAL = 28338,
  localparam int         NP          = 2 * WIDTH,
  localparam int         CW          = $clog2(2 * WIDTH + 1),
  localparam int         PW          = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] sig,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [63:0]      evt_index,
  output logic [CW-1:0]    covered_count,
  output logic             all_covered
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             primed_q, primed_d;
  logic [NP-1:0]    hit_q, hit_d;
  logic [NP-1:0]    pend_q, pend_d;
  logic             vld_q, vld_d;
  logic [63:0]      idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             all_q, all_d;

  logic [NP-1:0]    new_pts;
  logic [NP-1:0]    take;
  logic [CW-1:0]    new_cnt;
  logic [PW-1:0]    sel_p;
  logic             sel_vld;
  logic             load;

  // The design-wide total only documents the instance's place in the global point space.
  if (COVER_TOTAL < 0) begin : g_total_unused
  end

  always_comb begin
    new_pts = '0;
    if (en && primed_q) begin
      for (int b = 0; b < WIDTH; b++) begin
        new_pts[2*b]   = ~prev_q[b] & sig[b];
        new_pts[2*b+1] = prev_q[b] & ~sig[b];
      end
    end
    new_pts = new_pts & ~hit_q;
    new_cnt = '0;
    for (int i = 0; i < NP; i++) begin
      new_cnt = new_cnt + CW'(new_pts[i]);
    end
  end

  // Scanning downward leaves the lowest pending point selected.
  always_comb begin
    sel_vld = 1'b0;
    sel_p   = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_vld = 1'b1;
        sel_p   = PW'(i);
      end
    end
  end

  assign load = ~vld_q | evt_ready;

  always_comb begin
    take = '0;
    if (load && sel_vld) begin
      take[sel_p] = 1'b1;
    end
  end

  always_comb begin
    prev_d   = prev_q;
    primed_d = primed_q;
    hit_d    = hit_q | new_pts;
    pend_d   = (pend_q & ~take) | new_pts;
    cnt_d    = cnt_q + new_cnt;
    vld_d    = vld_q;
    idx_d    = idx_q;
    if (en) begin
      prev_d   = sig;
      primed_d = 1'b1;
    end
    if (load) begin
      vld_d = sel_vld;
      if (sel_vld) begin
        idx_d = COVER_INDEX + 64'(sel_p);
      end
    end
    if (clear) begin
      prev_d   = prev_q;
      primed_d = 1'b0;
      hit_d    = '0;
      pend_d   = '0;
      cnt_d    = '0;
      vld_d    = 1'b0;
    end
    all_d = (cnt_d == CW'(NP));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
      hit_q    <= '0;
      pend_q   <= '0;
      vld_q    <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      all_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      hit_q    <= hit_d;
      pend_q   <= pend_d;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      all_q    <= all_d;
    end
  end

  assign evt_valid     = vld_q;
  assign evt_index     = idx_q;
  assign covered_count = cnt_q;
  assign all_covered   = all_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Bench for toggle_cover_collector: a wide instance checked against an event-level model, a 3-bit instance for full coverage.
module tb_toggle_cover_collector;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        en_a, clear_a, rdy_a, vld_a, all_a;
  logic [64:0] sig_a;
  logic [63:0] idx_a;
  logic [7:0]  cnt_a;
  logic        en_b, clear_b, rdy_b, vld_b, all_b;
  logic [2:0]  sig_b;
  logic [63:0] idx_b;
  logic [2:0]  cnt_b;

  toggle_cover_collector #(.WIDTH(65), .COVER_INDEX(64'd100), .COVER_TOTAL(28338)) dut_a (
    .clock(clock), .reset(reset), .en(en_a), .clear(clear_a), .sig(sig_a),
    .evt_valid(vld_a), .evt_ready(rdy_a), .evt_index(idx_a),
    .covered_count(cnt_a), .all_covered(all_a));

  toggle_cover_collector #(.WIDTH(3), .COVER_INDEX(64'd0), .COVER_TOTAL(6)) dut_b (
    .clock(clock), .reset(reset), .en(en_b), .clear(clear_b), .sig(sig_b),
    .evt_valid(vld_b), .evt_ready(rdy_b), .evt_index(idx_b),
    .covered_count(cnt_b), .all_covered(all_b));

  int vectors = 0;
  int miscompares = 0;
  longint unsigned got[$];
  longint unsigned got_b[$];

  // Reference model: sets of hit and pending points plus one presented event.
  bit              m_prev[65];
  bit              m_primed;
  bit              m_hit[130];
  bit              m_pend[130];
  bit              m_vld;
  longint unsigned m_idx;
  int              m_cnt;

  task automatic model_reset();
    foreach (m_prev[b]) m_prev[b] = 1'b0;
    foreach (m_hit[p]) begin m_hit[p] = 1'b0; m_pend[p] = 1'b0; end
    m_primed = 1'b0; m_vld = 1'b0; m_idx = 0; m_cnt = 0;
  endtask

  task automatic model_mark(input int p);
    if (!m_hit[p]) begin
      m_hit[p] = 1'b1; m_pend[p] = 1'b1; m_cnt++;
    end
  endtask

  task automatic model_step();
    int p;
    if (!reset) begin model_reset(); return; end
    if (clear_a) begin
      foreach (m_hit[i]) begin m_hit[i] = 1'b0; m_pend[i] = 1'b0; end
      m_primed = 1'b0; m_vld = 1'b0; m_cnt = 0;
      return;
    end
    if (!m_vld || rdy_a) begin
      p = -1;
      for (int i = 129; i >= 0; i--) if (m_pend[i]) p = i;
      if (p >= 0) begin
        m_vld = 1'b1; m_idx = 100 + longint'(p); m_pend[p] = 1'b0;
      end else begin
        m_vld = 1'b0;
      end
    end
    if (en_a) begin
      if (m_primed) begin
        for (int b = 0; b < 65; b++) begin
          if (!m_prev[b] && sig_a[b]) model_mark(2 * b);
          if (m_prev[b] && !sig_a[b]) model_mark(2 * b + 1);
        end
      end
      for (int b = 0; b < 65; b++) m_prev[b] = sig_a[b];
      m_primed = 1'b1;
    end
  endtask

  function automatic bit model_match();
    return (vld_a === m_vld) && (!m_vld || idx_a === m_idx) &&
           (cnt_a === 8'(m_cnt)) && (all_a === (m_cnt == 130));
  endfunction

  // Records transfers happening on the coming edge, then advances one cycle.
  task automatic step();
    if (vld_a && rdy_a) got.push_back(idx_a);
    if (vld_b && rdy_b) got_b.push_back(idx_b);
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sig_a = 65'({$urandom(), $urandom(), $urandom()});
      sig_b = 3'($urandom());
      step();
      vectors++;
      if ({vld_a, idx_a, cnt_a, all_a, vld_b, idx_b, cnt_b, all_b} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: vld=%b idx=%0d cnt=%0d all=%b b:%b %0d %0d %b, want all zero",
                 vld_a, idx_a, cnt_a, all_a, vld_b, idx_b, cnt_b, all_b);
      end
    end
    reset = 1'b1; en_a = 1'b1; sig_a = '0; got.delete();
    step(); step();
    vectors++;
    if (vld_a !== 1'b0 || got.size() != 0 || !model_match()) begin
      miscompares++;
      $display("FAIL reset_idle: vld=%b events=%0d cnt=%0d, want vld=0 events=0 cnt=0", vld_a, got.size(), cnt_a);
    end
  endtask

  task automatic test_single();
    rdy_a = 1'b1; got.delete();
    sig_a[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) sig_a[3] = 1'b0;
      step();
      vectors++;
      if (!model_match()) begin
        miscompares++;
        $display("FAIL single_model cyc%0d: vld=%b idx=%0d cnt=%0d, want vld=%b idx=%0d cnt=%0d",
                 i, vld_a, idx_a, cnt_a, m_vld, m_idx, m_cnt);
      end
    end
    vectors++;
    if (got.size() != 2 || got[0] != 106 || got[1] != 107 || cnt_a !== 8'd2) begin
      miscompares++;
      $display("FAIL single_events: n=%0d first=%0d last=%0d cnt=%0d, want n=2 106 107 cnt=2",
               got.size(), (got.size() > 0) ? got[0] : 0, (got.size() > 0) ? got[$] : 0, cnt_a);
    end
    sig_a[3] = 1'b1; step(); step();
    sig_a[3] = 1'b0; step(); step(); step();
    vectors++;
    if (got.size() != 2 || vld_a !== 1'b0 || cnt_a !== 8'd2) begin
      miscompares++;
      $display("FAIL single_repeat: n=%0d vld=%b cnt=%0d, want n=2 vld=0 cnt=2", got.size(), vld_a, cnt_a);
    end
  endtask

  task automatic test_backpressure();
    longint unsigned exp_bp[5] = '{100, 102, 104, 106, 108};
    reset = 1'b0; step(); reset = 1'b1;
    en_a = 1'b1; sig_a = '0; step();
    rdy_a = 1'b0; sig_a = 65'h1F; got.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (i >= 1 && (vld_a !== 1'b1 || idx_a !== 64'd100)) begin
        miscompares++;
        $display("FAIL bp_hold cyc%0d: vld=%b idx=%0d, want vld=1 idx=100", i, vld_a, idx_a);
      end
    end
    rdy_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (!model_match()) begin
        miscompares++;
        $display("FAIL bp_model cyc%0d: vld=%b idx=%0d cnt=%0d, want vld=%b idx=%0d cnt=%0d",
                 i, vld_a, idx_a, cnt_a, m_vld, m_idx, m_cnt);
      end
    end
    vectors++;
    if (got.size() != 5 || cnt_a !== 8'd5) begin
      miscompares++;
      $display("FAIL bp_count: n=%0d cnt=%0d, want n=5 cnt=5", got.size(), cnt_a);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (got[i] != exp_bp[i]) begin
          miscompares++;
          $display("FAIL bp_order[%0d]: idx=%0d, want %0d", i, got[i], exp_bp[i]);
        end
      end
    end
  endtask

  task automatic test_clear();
    rdy_a = 1'b0; sig_a = 65'h10;
    step(); step();
    vectors++;
    if (vld_a !== 1'b1 || idx_a !== 64'd101 || cnt_a !== 8'd9) begin
      miscompares++;
      $display("FAIL clear_setup: vld=%b idx=%0d cnt=%0d, want vld=1 idx=101 cnt=9", vld_a, idx_a, cnt_a);
    end
    clear_a = 1'b1; step(); clear_a = 1'b0;
    vectors++;
    if (vld_a !== 1'b0 || cnt_a !== 8'd0 || all_a !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_flush: vld=%b cnt=%0d all=%b, want 0 0 0", vld_a, cnt_a, all_a);
    end
    step(); step();
    vectors++;
    if (vld_a !== 1'b0 || cnt_a !== 8'd0) begin
      miscompares++;
      $display("FAIL clear_prime: vld=%b cnt=%0d, want vld=0 cnt=0", vld_a, cnt_a);
    end
    sig_a[0] = 1'b1; rdy_a = 1'b1;
    step(); step();
    vectors++;
    if (vld_a !== 1'b1 || idx_a !== 64'd100 || !model_match()) begin
      miscompares++;
      $display("FAIL clear_rereport: vld=%b idx=%0d, want vld=1 idx=100", vld_a, idx_a);
    end
    step();
  endtask

  task automatic test_enable();
    logic [64:0] frozen;
    got.delete();
    sig_a[5] = 1'b1; sig_a[6] = 1'b1;
    step();
    frozen = sig_a; en_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sig_a = 65'({$urandom(), $urandom(), $urandom()});
      step();
      vectors++;
      if (!model_match()) begin
        miscompares++;
        $display("FAIL en_model cyc%0d: vld=%b idx=%0d cnt=%0d, want vld=%b idx=%0d cnt=%0d",
                 i, vld_a, idx_a, cnt_a, m_vld, m_idx, m_cnt);
      end
    end
    vectors++;
    if (got.size() != 2 || got[0] != 110 || got[1] != 112 || cnt_a !== 8'd3) begin
      miscompares++;
      $display("FAIL en_drain: n=%0d cnt=%0d, want n=2 (110,112) cnt=3", got.size(), cnt_a);
    end
    sig_a = frozen; sig_a[20] = 1'b1; en_a = 1'b1;
    step(); step();
    vectors++;
    if (vld_a !== 1'b1 || idx_a !== 64'd140) begin
      miscompares++;
      $display("FAIL en_stale_prev: vld=%b idx=%0d, want vld=1 idx=140", vld_a, idx_a);
    end
    step();
  endtask

  task automatic test_width3();
    longint unsigned exp_w3[6] = '{0, 1, 2, 3, 4, 5};
    en_b = 1'b1; rdy_b = 1'b1; sig_b = 3'b000; got_b.delete();
    step();
    sig_b = 3'b111; step();
    vectors++;
    if (cnt_b !== 3'd3 || all_b !== 1'b0) begin
      miscompares++;
      $display("FAIL w3_half: cnt=%0d all=%b, want cnt=3 all=0", cnt_b, all_b);
    end
    sig_b = 3'b000;
    for (int i = 0; i < 9; i++) step();
    vectors++;
    if (got_b.size() != 6 || cnt_b !== 3'd6 || all_b !== 1'b1) begin
      miscompares++;
      $display("FAIL w3_full: n=%0d cnt=%0d all=%b, want n=6 cnt=6 all=1", got_b.size(), cnt_b, all_b);
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (got_b[i] != exp_w3[i]) begin
          miscompares++;
          $display("FAIL w3_order[%0d]: idx=%0d, want %0d", i, got_b[i], exp_w3[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    rdy_a = 1'b0; sig_a[30] = ~sig_a[30];
    step(); step();
    vectors++;
    if (vld_a !== 1'b1 || !model_match()) begin
      miscompares++;
      $display("FAIL areset_setup: vld=%b idx=%0d, want vld=1 idx=%0d", vld_a, idx_a, m_idx);
    end
    #2 reset = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (vld_a !== 1'b0 || idx_a !== 64'd0 || cnt_a !== 8'd0 || all_a !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_drop: vld=%b idx=%0d cnt=%0d, want all zero", vld_a, idx_a, cnt_a);
    end
    step(); reset = 1'b1; rdy_a = 1'b1; got.delete();
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (got.size() != 0 || vld_a !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_replay: events=%0d vld=%b, want 0 0", got.size(), vld_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en_a    = ($urandom_range(9) < 8);
      rdy_a   = ($urandom_range(9) < 7);
      clear_a = ($urandom_range(99) < 2);
      for (int k = $urandom_range(3); k > 0; k--) sig_a[$urandom_range(64)] ^= 1'b1;
      step();
      vectors++;
      if (!model_match()) begin
        miscompares++;
        $display("FAIL random_model cyc%0d: vld=%b idx=%0d cnt=%0d all=%b, want vld=%b idx=%0d cnt=%0d",
                 i, vld_a, idx_a, cnt_a, all_a, m_vld, m_idx, m_cnt);
      end
    end
    clear_a = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en_a = 1'b0; clear_a = 1'b0; sig_a = '0; rdy_a = 1'b1;
    en_b = 1'b0; clear_b = 1'b0; sig_b = '0; rdy_b = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_clear();
    test_enable();
    test_width3();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
